// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_e : receiver FSM state encoding (IDLE = 0)
//   MAJ_PRE/MAJ_POST: majority-vote sample offsets around the mid-bit phase
//   maj3            : 2-of-3 majority helper
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA       = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    EXTRA_STOP = 3'd5
  } uart_rx_state_e;

  // First vote sample is taken MAJ_PRE phases before mid-bit; the vote is
  // resolved MAJ_POST phases after mid-bit using the live synchronised line.
  localparam int unsigned MAJ_PRE  = 1;
  localparam int unsigned MAJ_POST = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous rx line plus one
// extra flop holding the previous synchronised value for edge detection.
//   clk_i   : oversample clock
//   arst_ni : asynchronous active-low reset (all flops reset to line idle, 1)
//   rx_i    : raw serial line
//   rx_s    : synchronised line
//   rx_q    : rx_s delayed by one cycle
module uart_rx_sync (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic rx_i,
  output logic rx_s,
  output logic rx_q
);

  logic meta;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      meta <= rx_i;
      rx_s <= meta;
      rx_q <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 8N1/8E1/8N2/8E2 frames with 3-sample mid-bit
// majority voting, presenting bytes over a valid/ready holding register.
//   clk_i, arst_ni         : oversample clock, async active-low reset
//   rx_i                   : serial line, idle high
//   parity_en_i            : expect even parity after the 8 data bits
//   extra_stop_i           : expect two stop bits
//   data_o, data_valid_o   : held byte and its valid flag
//   data_ready_i           : consumer accepts the held byte
//   parity_err_o           : parity mismatch for the held byte
//   frame_err_o            : a stop bit was sampled low for the held byte
//   overrun_o              : 1-cycle pulse, frame dropped (holding reg full)
//   busy_o                 : receiver is inside a frame
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       rx_i,
  input  logic       parity_en_i,
  input  logic       extra_stop_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] PH_A    = CNT_W'(MID - MAJ_PRE);
  localparam logic [CNT_W-1:0] PH_B    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] PH_VOTE = CNT_W'(MID + MAJ_POST);
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(OVERSAMPLE - 1);

  logic rx_s, rx_q;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .rx_i   (rx_i),
    .rx_s   (rx_s),
    .rx_q   (rx_q)
  );

  uart_rx_state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg;
  logic s_a, s_b;
  logic par_en_q, two_stop_q;
  logic perr_q, ferr_q;

  logic vote, at_vote, at_last;
  logic latch_cfg, shift_en, perr_set, ferr_set, complete;

  assign vote    = maj3(s_a, s_b, rx_s);
  assign at_vote = (cnt == PH_VOTE);
  assign at_last = (cnt == PH_LAST);
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    latch_cfg = 1'b0;
    shift_en  = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        // Requires a seen 1 before the 0, so a stuck-low line cannot retrigger.
        if (rx_q && !rx_s) begin
          state_n   = START_BIT;
          latch_cfg = 1'b1;
        end
      end
      START_BIT: begin
        if (at_vote && vote) begin
          state_n = IDLE;
        end else if (at_last) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        shift_en = at_vote;
        if (at_last) begin
          if (idx == 3'd7) state_n = par_en_q ? PARITY_BIT : STOP_BIT;
          else             idx_n   = idx + 3'd1;
        end
      end
      PARITY_BIT: begin
        perr_set = at_vote;
        if (at_last) state_n = STOP_BIT;
      end
      STOP_BIT: begin
        // Single-stop frames finish at mid-bit so the next start edge is
        // never missed when the transmitter runs slightly fast.
        if (at_vote) begin
          ferr_set = 1'b1;
          if (!two_stop_q) begin
            complete = 1'b1;
            state_n  = IDLE;
          end
        end else if (at_last && two_stop_q) begin
          state_n = EXTRA_STOP;
        end
      end
      EXTRA_STOP: begin
        if (at_vote) begin
          ferr_set = 1'b1;
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      shreg      <= 8'h00;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      // Explicit wrap at PH_LAST keeps non-power-of-two OVERSAMPLE correct.
      if (state_n != state || at_last) cnt <= '0;
      else if (state != IDLE)          cnt <= cnt + 1'b1;
      if (cnt == PH_A) s_a <= rx_s;
      if (cnt == PH_B) s_b <= rx_s;
      if (latch_cfg) begin
        par_en_q   <= parity_en_i;
        two_stop_q <= extra_stop_i;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
      end
      if (shift_en) shreg[idx] <= vote;
      if (perr_set) perr_q <= vote ^ (^shreg);
      if (ferr_set) ferr_q <= ferr_q | ~vote;
    end
  end

  // Output holding register. The error flag of the final stop bit is folded
  // in combinationally because completion happens in the same cycle.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (complete && (!data_valid_o || data_ready_i)) begin
        data_o       <= shreg;
        parity_err_o <= perr_q;
        frame_err_o  <= ferr_q | ~vote;
        data_valid_o <= 1'b1;
      end else begin
        if (complete) overrun_o <= 1'b1;
        if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed bench for uart_rx. A line driver builds
// each frame from its byte and options, and the expected byte/flags come from
// the frame contents (parity = even parity of the byte, frame error = any stop
// bit sent low).
module tb_uart_rx;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       rx_i;
  logic       parity_en_i;
  logic       extra_stop_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .rx_i        (rx_i),
    .parity_en_i (parity_en_i),
    .extra_stop_i(extra_stop_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Free-running edge counter and passive monitors sampled on the falling edge.
  int   cyc       = 0;
  int   last_rise = -1;
  int   ov_cnt    = 0;
  int   ov_cyc    = -1;
  int   inv_cnt   = 0;
  int   busy_cnt  = 0;
  logic prev_valid = 1'b0;
  int   last_t0   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    prev_valid <= data_valid_o;
    if (data_valid_o && !prev_valid) last_rise <= cyc;
    if (overrun_o) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    if (!data_valid_o) inv_cnt <= inv_cnt + 1;
    if (busy_o) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives one frame; period is the bit length in hundredths of a clock.
  // Must be entered just after a rising edge; returns just after one.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit two,
                            input bit bad_par, input bit bad_stop, input int period);
    logic bits [12];
    int nb, total;
    parity_en_i  = pe;
    extra_stop_i = two;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pe) begin
      bits[nb] = (^d) ^ bad_par;
      nb++;
    end
    bits[nb] = !bad_stop;
    nb++;
    if (two) begin
      bits[nb] = 1'b1;
      nb++;
    end
    total   = (nb * period + 99) / 100;
    last_t0 = cyc + 1;
    for (int n = 0; n < total; n++) begin
      rx_i = bits[(n * 100) / period];
      @(posedge clk_i); #1;
    end
    rx_i = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 400 && !data_valid_o; i++) begin @(posedge clk_i); #1; end
    chk("valid_timeout", data_valid_o, 1'b1);
  endtask

  task automatic consume();
    data_ready_i = 1'b1;
    @(posedge clk_i); #1;
    data_ready_i = 1'b0;
    chk("valid_clear", data_valid_o, 1'b0);
  endtask

  task automatic expect_byte(input logic [7:0] d, input bit perr, input bit ferr);
    wait_valid();
    chk("data", data_o, d);
    chk("parity_err", parity_err_o, perr);
    chk("frame_err", frame_err_o, ferr);
  endtask

  initial begin
    int t0, ov0, inv0, busy0;
    logic [7:0] rd;
    bit pe, two, bp, bs;

    arst_ni = 1'b0; rx_i = 1'b1; parity_en_i = 1'b0; extra_stop_i = 1'b0;
    data_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", data_valid_o, 1'b0);
    chk("rst_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);
    chk("rst_busy", busy_o, 1'b0);
    arst_ni = 1'b1;
    idle(4);

    // Basic 8N1 frame and latency. rx_s reads the start bit one edge after
    // the line is first sampled low; 155 edges from there gives 156 here.
    send_frame(8'hA5, 0, 0, 0, 0, 1600);
    t0 = last_t0;
    expect_byte(8'hA5, 0, 0);
    chk("latency", last_rise - t0, 156);
    consume();
    idle(5);

    // Parity good, then parity bad (byte still delivered).
    send_frame(8'h07, 1, 0, 0, 0, 1600);
    expect_byte(8'h07, 0, 0);
    consume();
    idle(5);
    send_frame(8'h07, 1, 0, 1, 0, 1600);
    expect_byte(8'h07, 1, 0);
    consume();
    idle(5);

    // Stop bit forced low.
    send_frame(8'h3C, 0, 0, 0, 1, 1600);
    expect_byte(8'h3C, 0, 1);
    consume();
    idle(5);

    // Short low glitch on an idle line: false start, nothing delivered.
    busy0 = busy_cnt;
    rx_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    idle(40);
    chk("glitch_seen", busy_cnt > busy0, 1'b1);
    chk("glitch_busy", busy_o, 1'b0);
    chk("glitch_valid", data_valid_o, 1'b0);

    // Overrun: second frame completes while the first is still held.
    ov0 = ov_cnt;
    send_frame(8'h11, 0, 0, 0, 0, 1600);
    idle(4);
    send_frame(8'h22, 0, 0, 0, 0, 1600);
    t0 = last_t0;
    idle(10);
    chk("ovr_data", data_o, 8'h11);
    chk("ovr_valid", data_valid_o, 1'b1);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_when", ov_cyc - t0, 156);
    consume();
    idle(5);

    // Back-to-back 8N2 frames, ready pulsed exactly in 0xAA's completion
    // cycle (EXTRA_STOP mid-bit, loaded on edge 172 after the start sample).
    send_frame(8'h55, 0, 1, 0, 0, 1600);
    chk("b2b_first", data_o, 8'h55);
    ov0  = ov_cnt;
    inv0 = inv_cnt;
    fork
      send_frame(8'hAA, 0, 1, 0, 0, 1600);
      begin
        repeat (172) @(posedge clk_i);
        #1 data_ready_i = 1'b1;
        @(posedge clk_i);
        #1 data_ready_i = 1'b0;
      end
    join
    chk("b2b_data", data_o, 8'hAA);
    chk("b2b_no_drop", inv_cnt - inv0, 0);
    chk("b2b_no_ovr", ov_cnt - ov0, 0);
    consume();
    idle(5);

    // Transmitter 3% fast and 3% slow.
    send_frame(8'h96, 0, 0, 0, 0, 1552);
    expect_byte(8'h96, 0, 0);
    consume();
    idle(3);
    send_frame(8'h69, 0, 0, 0, 0, 1648);
    expect_byte(8'h69, 0, 0);
    consume();
    idle(5);

    // Randomized frames across all formats and error injections.
    for (int k = 0; k < 12; k++) begin
      rd  = 8'($urandom);
      pe  = 1'($urandom);
      two = 1'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 3) == 0);
      send_frame(rd, pe, two, bp, bs, 1600);
      expect_byte(rd, pe & bp, bs);
      consume();
      idle($urandom_range(4, 20));
    end

    // Reset during DATA_4 abandons the frame; the next frame is clean.
    chk("pre_rst_valid", data_valid_o, 1'b0);
    fork
      send_frame(8'h5A, 0, 0, 0, 0, 1600);
      begin
        repeat (90) @(posedge clk_i);
        #1 chk("mid_busy", busy_o, 1'b1);
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_data", data_o, 8'h00);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_out", {data_valid_o, parity_err_o, frame_err_o, overrun_o}, 4'b0000);
      end
    join
    arst_ni = 1'b1;
    idle(5);
    chk("post_rst_idle", data_valid_o, 1'b0);
    send_frame(8'hC3, 0, 0, 0, 0, 1600);
    expect_byte(8'hC3, 0, 0);
    consume();
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
